endnode_rx_buffer: RTL and testbench
====================================

Name: endnode_rx_buffer

Overview:
- Receive-side packet buffer directly downstream of the endnode RX path.
- Captures decoded flits (flit_rx/done_rx) into a FIFO and holds each packet uncommitted until its end-of-packet CRC/error verdict.
- Good packets: committed, made visible to the local consumer, and an ACK request is queued toward the endnode TX side.
- Bad packets (CRC fail, UART error, or overflow): rolled back.
- Returns one grtcred pulse per flit drained, on that flit's VC.

Parameters:
- DEPTH, 8, flit storage entries; power of 2, ≥4.
- ACK_DEPTH, 2, pending ACK header entries; power of 2, ≥2.

Ports:
- CLK  input  1  clock.
- RST  input  1  synchronous active-high reset.
- flit_rx  input  flit_t  decoded flit from endnode RX.
- done_rx  input  1  flit_rx valid strobe, one cycle per flit.
- packet_done_rx  input  1  end-of-packet strobe; crc_corr_rx and err_rx are sampled this cycle.
- crc_corr_rx  input  1  packet CRC correct.
- err_rx  input  1  sticky UART/PHY error for the current packet.
- flit_out  output  flit_t  head committed flit.
- flit_valid  output  1  committed flit available.
- flit_ready  input  1  consumer accepts flit_out.
- ack_valid  output  1  ACK request pending.
- ack_hdr  output  {vc,id,req} metadata  header of the committed packet to ACK.
- ack_ready  input  1  TX side accepted the ACK.
- grtcred_tx  output  2  one-cycle credit return per VC.
- drop_cnt  output  16  packets discarded; saturates at 65535.
- overflow  output  1  sticky: a flit arrived while storage was full.

Behaviour:
- Pointers:
  - wptr, cptr (commit) and rptr are each log2(DEPTH)+1 bits and wrap naturally.
  - full = (wptr-rptr)==DEPTH.
  - flit_valid = (rptr!=cptr).
  - flit_out = mem[rptr[low bits]], combinational from registered storage.
- Reset:
  - All pointers 0; bad, overflow, drop_cnt, ack FIFO, grtcred_tx all 0.
  - flit_valid=0, ack_valid=0.
  - Storage contents are don't-care.
  - Reset mid-packet discards everything with no ACK or credit.
- Write: done_rx && !full → mem[wptr]=flit_rx, wptr+1.
  - If this is the first flit since the last commit/rollback (wptr==cptr before the write), latch its {vc,id,req} into hdr_hold.
- Overflow: done_rx && full → flit dropped, bad=1, overflow=1 (sticky until RST).
- Commit: packet_done_rx && crc_corr_rx && !err_rx && !bad.
  - cptr ← wptr, including any flit written the same cycle.
  - Push hdr_hold into the ACK FIFO; if done_rx also wrote a first flit this cycle, push that flit's header.
- Rollback: packet_done_rx otherwise.
  - wptr ← cptr; a same-cycle done_rx flit is discarded too.
  - bad ← 0; drop_cnt+1 (saturating).
  - No ACK.
- Boundary cases:
  - packet_done_rx with no flits since the last boundary and a good verdict: counts as commit with an empty range; pushes an ACK only if a header was latched, else no-op.
  - ACK FIFO full at commit: data is still committed; ACK dropped; drop_cnt is not incremented.
- Read: flit_valid && flit_ready → rptr+1.
  - Next cycle grtcred_tx[vc]=1 for the popped flit's metadata.vc, one cycle only.
  - One pop per cycle, so at most one credit bit per cycle.
- ACK output:
  - ack_valid = ACK FIFO non-empty; ack_hdr = head entry.
  - ack_valid && ack_ready pops.
  - Push and pop in the same cycle are both honoured.
- Rollback never moves below cptr.
  - A same-cycle pop and rollback are independent: rptr advances, wptr←cptr.
- Single clock domain. All outputs are registered except flit_out, flit_valid, ack_valid and ack_hdr, which decode registered state.

Test Plan:
- RST; three flits on VC0 (id=2,req=1) then packet_done_rx with crc_corr_rx=1, err_rx=0 → flit_valid rises the cycle after commit; ack_valid=1 with ack_hdr={0,2,1}; after 3 pops, grtcred_tx=2'b01 for 3 cycles, each one cycle after its pop.
- Two flits then packet_done_rx with crc_corr_rx=0 → flit_valid stays 0, drop_cnt=1, no ACK; the next good packet is read intact from the old wptr position.
- DEPTH=8, flit_ready=0, 9 flits then good verdict → overflow=1, packet dropped, drop_cnt=1, wptr==cptr==0.
- Last flit and packet_done_rx in the same cycle (good) → that flit is committed; 4 flits readable.
- Good packet while ACK FIFO holds 2 entries and ack_ready=0 → data committed, third ACK dropped; after two ack_ready pulses, ack_valid=0.
- err_rx=1 at packet_done_rx with crc_corr_rx=1 → rollback; drop_cnt increments; RST mid-packet → all outputs 0 next cycle.

Source files
------------

// File: rtl/endnode_rx_buffer.sv
// Receive packet buffer: holds flits uncommitted until the end-of-packet verdict, then commits
// (queueing an ACK header) or rolls back. Returns one credit per drained flit on its VC.
module endnode_rx_buffer #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned ACK_DEPTH = 2,
  // Flit layout: {vc[13], id[12:9], req[8], payload[7:0]}; ACK header is the top HDR_W bits.
  localparam int unsigned FLIT_W = 14,
  localparam int unsigned HDR_W  = 6
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLIT_W-1:0] flit_rx,
  input  logic              done_rx,
  input  logic              packet_done_rx,
  input  logic              crc_corr_rx,
  input  logic              err_rx,
  output logic [FLIT_W-1:0] flit_out,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic              ack_valid,
  output logic [HDR_W-1:0]  ack_hdr,
  input  logic              ack_ready,
  output logic [1:0]        grtcred_tx,
  output logic [15:0]       drop_cnt,
  output logic              overflow
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned AAW = $clog2(ACK_DEPTH);
  localparam logic [AW:0]  FULL_CNT     = (AW + 1)'(DEPTH);
  localparam logic [AAW:0] ACK_FULL_CNT = (AAW + 1)'(ACK_DEPTH);

  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [HDR_W-1:0]  ack_mem_q [ACK_DEPTH];

  logic [AW:0]      wptr_q, wptr_d, cptr_q, cptr_d, rptr_q, rptr_d;
  logic [AAW:0]     ack_wptr_q, ack_wptr_d, ack_rptr_q, ack_rptr_d;
  logic [HDR_W-1:0] hdr_hold_q, hdr_hold_d;
  logic             hdr_vld_q, hdr_vld_d;
  logic             bad_q, bad_d;
  logic             overflow_q, overflow_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;
  logic [1:0]       grtcred_q, grtcred_d;

  logic             full, wr_en, ovf, first_wr, pop;
  logic             ack_full, ack_pop, ack_push, commit, rollback;
  logic [HDR_W-1:0] push_hdr;

  assign flit_valid = (rptr_q != cptr_q);
  assign flit_out   = mem_q[rptr_q[AW-1:0]];
  assign ack_valid  = (ack_wptr_q != ack_rptr_q);
  assign ack_hdr    = ack_mem_q[ack_rptr_q[AAW-1:0]];
  assign grtcred_tx = grtcred_q;
  assign drop_cnt   = drop_cnt_q;
  assign overflow   = overflow_q;

  assign full     = ((wptr_q - rptr_q) == FULL_CNT);
  assign wr_en    = done_rx && !full;
  assign ovf      = done_rx && full;
  assign first_wr = wr_en && (wptr_q == cptr_q);
  assign pop      = flit_valid && flit_ready;
  assign ack_full = ((ack_wptr_q - ack_rptr_q) == ACK_FULL_CNT);
  assign ack_pop  = ack_valid && ack_ready;
  // A flit dropped in the verdict cycle still spoils the packet.
  assign commit   = packet_done_rx && crc_corr_rx && !err_rx && !bad_q && !ovf;
  assign rollback = packet_done_rx && !commit;
  assign push_hdr = first_wr ? flit_rx[FLIT_W-1 -: HDR_W] : hdr_hold_q;
  assign ack_push = commit && (first_wr || hdr_vld_q) && (!ack_full || ack_pop);

  always_comb begin
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    rptr_d     = rptr_q;
    hdr_hold_d = hdr_hold_q;
    hdr_vld_d  = hdr_vld_q;
    bad_d      = bad_q;
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    grtcred_d  = '0;
    ack_wptr_d = ack_wptr_q;
    ack_rptr_d = ack_rptr_q;

    if (wr_en) wptr_d = wptr_q + 1'b1;
    if (first_wr) begin
      hdr_hold_d = flit_rx[FLIT_W-1 -: HDR_W];
      hdr_vld_d  = 1'b1;
    end
    if (ovf) begin
      bad_d      = 1'b1;
      overflow_d = 1'b1;
    end
    if (commit) begin
      cptr_d    = wptr_d;
      hdr_vld_d = 1'b0;
    end
    if (rollback) begin
      wptr_d    = cptr_q;
      bad_d     = 1'b0;
      hdr_vld_d = 1'b0;
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
    end
    if (pop) begin
      rptr_d                      = rptr_q + 1'b1;
      grtcred_d[flit_out[FLIT_W-1]] = 1'b1;
    end
    if (ack_push) ack_wptr_d = ack_wptr_q + 1'b1;
    if (ack_pop)  ack_rptr_d = ack_rptr_q + 1'b1;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr_q     <= '0;
      cptr_q     <= '0;
      rptr_q     <= '0;
      hdr_hold_q <= '0;
      hdr_vld_q  <= 1'b0;
      bad_q      <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
      grtcred_q  <= '0;
      ack_wptr_q <= '0;
      ack_rptr_q <= '0;
    end else begin
      wptr_q     <= wptr_d;
      cptr_q     <= cptr_d;
      rptr_q     <= rptr_d;
      hdr_hold_q <= hdr_hold_d;
      hdr_vld_q  <= hdr_vld_d;
      bad_q      <= bad_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
      grtcred_q  <= grtcred_d;
      ack_wptr_q <= ack_wptr_d;
      ack_rptr_q <= ack_rptr_d;
    end
  end

  // Storage needs no reset; pointers define what is live.
  always_ff @(posedge CLK) begin
    if (wr_en)    mem_q[wptr_q[AW-1:0]]          <= flit_rx;
    if (ack_push) ack_mem_q[ack_wptr_q[AAW-1:0]] <= push_hdr;
  end

endmodule

// File: tb/tb_endnode_rx_buffer.sv
// Bench for endnode_rx_buffer: directed vector table, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_endnode_rx_buffer;

  localparam int DEPTH     = 8;
  localparam int ACK_DEPTH = 2;

  logic        CLK = 1'b0;
  logic        RST, done_rx, packet_done_rx, crc_corr_rx, err_rx, flit_ready, ack_ready;
  logic [13:0] flit_rx;
  logic [13:0] flit_out;
  logic        flit_valid, ack_valid, overflow;
  logic [5:0]  ack_hdr;
  logic [1:0]  grtcred_tx;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  endnode_rx_buffer #(.DEPTH(DEPTH), .ACK_DEPTH(ACK_DEPTH)) dut (
    .CLK(CLK), .RST(RST), .flit_rx(flit_rx), .done_rx(done_rx),
    .packet_done_rx(packet_done_rx), .crc_corr_rx(crc_corr_rx), .err_rx(err_rx),
    .flit_out(flit_out), .flit_valid(flit_valid), .flit_ready(flit_ready),
    .ack_valid(ack_valid), .ack_hdr(ack_hdr), .ack_ready(ack_ready),
    .grtcred_tx(grtcred_tx), .drop_cnt(drop_cnt), .overflow(overflow)
  );

  always #5 CLK = ~CLK;

  // Reference model: committed-unread flits, uncommitted flits, pending ACK headers.
  logic [13:0] m_com[$];
  logic [13:0] m_pend[$];
  logic [5:0]  m_ack[$];
  bit          m_bad, m_hv, m_ovf;
  logic [5:0]  m_hdr;
  int          m_drop;
  logic [1:0]  m_cred;

  function automatic logic [13:0] mk(input logic vc, input logic [3:0] id, input logic req,
                                     input logic [7:0] pl);
    return {vc, id, req, pl};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit rst, input bit d, input logic [13:0] f, input bit pd,
                            input bit crc, input bit err, input bit rdy, input bit ardy);
    bit pop, apop, full, wr, ovf, first, have_hdr;
    logic [5:0] h;
    if (rst) begin
      m_com.delete(); m_pend.delete(); m_ack.delete();
      m_bad = 0; m_hv = 0; m_ovf = 0; m_hdr = '0; m_drop = 0; m_cred = '0;
      return;
    end
    pop   = (m_com.size() > 0) && rdy;
    apop  = (m_ack.size() > 0) && ardy;
    full  = (m_com.size() + m_pend.size()) == DEPTH;
    wr    = d && !full;
    ovf   = d && full;
    first = wr && (m_pend.size() == 0);
    m_cred = '0;
    if (pop) begin
      m_cred[m_com[0][13]] = 1'b1;
      void'(m_com.pop_front());
    end
    if (apop) void'(m_ack.pop_front());
    if (ovf) m_ovf = 1;
    if (pd) begin
      if (crc && !err && !m_bad && !ovf) begin
        if (wr) m_pend.push_back(f);
        have_hdr = first || m_hv;
        h = first ? f[13:8] : m_hdr;
        foreach (m_pend[i]) m_com.push_back(m_pend[i]);
        if (have_hdr && m_ack.size() < ACK_DEPTH) m_ack.push_back(h);
      end else begin
        if (m_drop < 65535) m_drop++;
        m_bad = 0;
      end
      m_pend.delete();
      m_hv = 0;
    end else begin
      if (wr) m_pend.push_back(f);
      if (first) begin m_hdr = f[13:8]; m_hv = 1; end
      if (ovf) m_bad = 1;
    end
  endtask

  task automatic model_check();
    chk("m_flit_valid", 32'(flit_valid), 32'(m_com.size() > 0));
    if (m_com.size() > 0) chk("m_flit_out", 32'(flit_out), 32'(m_com[0]));
    chk("m_ack_valid", 32'(ack_valid), 32'(m_ack.size() > 0));
    if (m_ack.size() > 0) chk("m_ack_hdr", 32'(ack_hdr), 32'(m_ack[0]));
    chk("m_grtcred", 32'(grtcred_tx), 32'(m_cred));
    chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drop));
    chk("m_overflow", 32'(overflow), 32'(m_ovf));
  endtask

  // Apply one cycle of inputs, advance the model alongside, sample #1 after the edge.
  task automatic cycle(input bit rst, input bit d, input logic [13:0] f, input bit pd,
                       input bit crc, input bit err, input bit rdy, input bit ardy);
    RST = rst; done_rx = d; flit_rx = f; packet_done_rx = pd;
    crc_corr_rx = crc; err_rx = err; flit_ready = rdy; ack_ready = ardy;
    @(posedge CLK);
    model_step(rst, d, f, pd, crc, err, rdy, ardy);
    #1;
    model_check();
  endtask

  typedef struct {
    bit d; logic [13:0] f; bit pd, crc, err, rdy, ardy;
    bit e_fv; logic [13:0] e_fout; bit e_av; logic [5:0] e_hdr; logic [1:0] e_cred; int e_drop;
  } vec_t;

  vec_t tv[15];
  logic [13:0] a0, a1, a2, b0, b1, c0, fx;

  initial begin
    RST = 1; done_rx = 0; flit_rx = '0; packet_done_rx = 0; crc_corr_rx = 0; err_rx = 0;
    flit_ready = 0; ack_ready = 0;

    a0 = mk(1'b0, 4'd2, 1'b1, 8'h10); a1 = mk(1'b0, 4'd2, 1'b1, 8'h11);
    a2 = mk(1'b0, 4'd2, 1'b1, 8'h12);
    b0 = mk(1'b1, 4'd5, 1'b0, 8'h20); b1 = mk(1'b1, 4'd5, 1'b0, 8'h21);
    c0 = mk(1'b1, 4'd3, 1'b1, 8'h30);
    //          d  f   pd crc err rdy ardy  fv fout av hdr     cred  drop
    tv[0]  = '{1, a0, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[1]  = '{1, a1, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[2]  = '{1, a2, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[3]  = '{0, '0, 1, 1, 0, 0, 0,  1, a0, 1, 6'h05, 2'b00, 0};
    tv[4]  = '{0, '0, 0, 0, 0, 1, 0,  1, a1, 1, 6'h05, 2'b01, 0};
    tv[5]  = '{0, '0, 0, 0, 0, 1, 0,  1, a2, 1, 6'h05, 2'b01, 0};
    tv[6]  = '{0, '0, 0, 0, 0, 1, 0,  0, '0, 1, 6'h05, 2'b01, 0};
    tv[7]  = '{0, '0, 0, 0, 0, 0, 1,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[8]  = '{1, b0, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[9]  = '{1, b1, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 0};
    tv[10] = '{0, '0, 1, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 1};
    tv[11] = '{1, c0, 0, 0, 0, 0, 0,  0, '0, 0, 6'h00, 2'b00, 1};
    tv[12] = '{0, '0, 1, 1, 0, 0, 0,  1, c0, 1, 6'h27, 2'b00, 1};
    tv[13] = '{0, '0, 0, 0, 0, 1, 0,  0, '0, 1, 6'h27, 2'b10, 1};
    tv[14] = '{0, '0, 0, 0, 0, 0, 1,  0, '0, 0, 6'h00, 2'b00, 1};

    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    chk("rst_flit_valid", 32'(flit_valid), 32'd0);
    chk("rst_ack_valid", 32'(ack_valid), 32'd0);
    chk("rst_grtcred", 32'(grtcred_tx), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);

    // Directed table: good packet drain with credits, then bad packet and replacement.
    foreach (tv[i]) begin
      cycle(0, tv[i].d, tv[i].f, tv[i].pd, tv[i].crc, tv[i].err, tv[i].rdy, tv[i].ardy);
      chk($sformatf("tv%0d_flit_valid", i), 32'(flit_valid), 32'(tv[i].e_fv));
      if (tv[i].e_fv) chk($sformatf("tv%0d_flit_out", i), 32'(flit_out), 32'(tv[i].e_fout));
      chk($sformatf("tv%0d_ack_valid", i), 32'(ack_valid), 32'(tv[i].e_av));
      if (tv[i].e_av) chk($sformatf("tv%0d_ack_hdr", i), 32'(ack_hdr), 32'(tv[i].e_hdr));
      chk($sformatf("tv%0d_grtcred", i), 32'(grtcred_tx), 32'(tv[i].e_cred));
      chk($sformatf("tv%0d_drop_cnt", i), 32'(drop_cnt), 32'(tv[i].e_drop));
    end

    // Overflow: nine flits into eight slots, then a good verdict is still a drop.
    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 9; i++) cycle(0, 1, mk(1'b0, 4'd1, 1'b0, 8'(i)), 0, 0, 0, 0, 0);
    chk("ovf_overflow", 32'(overflow), 32'd1);
    cycle(0, 0, '0, 1, 1, 0, 0, 0);
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("ovf_flit_valid", 32'(flit_valid), 32'd0);
    chk("ovf_ack_valid", 32'(ack_valid), 32'd0);
    fx = mk(1'b1, 4'd6, 1'b1, 8'hAA);
    cycle(0, 1, fx, 0, 0, 0, 0, 0);
    cycle(0, 0, '0, 1, 1, 0, 0, 0);
    chk("ovf_next_flit_out", 32'(flit_out), 32'(fx));
    chk("ovf_next_ack_hdr", 32'(ack_hdr), 32'(6'h2D));
    cycle(0, 0, '0, 0, 0, 0, 1, 0);
    chk("ovf_next_grtcred", 32'(grtcred_tx), 32'd2);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Last flit and verdict in the same cycle.
    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 1, mk(1'b0, 4'd4, 1'b0, 8'(8'h40 + i)), 0, 0, 0, 0, 0);
    cycle(0, 1, mk(1'b0, 4'd4, 1'b0, 8'h43), 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("same_flit%0d", i), 32'(flit_out), 32'(mk(1'b0, 4'd4, 1'b0, 8'(8'h40 + i))));
      cycle(0, 0, '0, 0, 0, 0, 1, 0);
    end
    chk("same_drained", 32'(flit_valid), 32'd0);

    // ACK FIFO full: third ACK dropped but its data still committed.
    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    for (int p = 0; p < 3; p++) begin
      cycle(0, 1, mk(1'b0, 4'(p), 1'b1, 8'(8'h50 + p)), 0, 0, 0, 0, 0);
      cycle(0, 0, '0, 1, 1, 0, 0, 0);
    end
    chk("ackf_hdr0", 32'(ack_hdr), 32'(6'h01));
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("ackf_flit%0d", i), 32'(flit_out), 32'(mk(1'b0, 4'(i), 1'b1, 8'(8'h50 + i))));
      cycle(0, 0, '0, 0, 0, 0, 1, 0);
    end
    chk("ackf_drained", 32'(flit_valid), 32'd0);
    cycle(0, 0, '0, 0, 0, 0, 0, 1);
    chk("ackf_hdr1", 32'(ack_hdr), 32'(6'h03));
    cycle(0, 0, '0, 0, 0, 0, 0, 1);
    chk("ackf_empty", 32'(ack_valid), 32'd0);
    chk("ackf_drop_cnt", 32'(drop_cnt), 32'd0);

    // err_rx with good CRC rolls back.
    cycle(0, 1, mk(1'b1, 4'd9, 1'b0, 8'h60), 0, 0, 0, 0, 0);
    cycle(0, 0, '0, 1, 1, 1, 0, 0);
    chk("err_drop_cnt", 32'(drop_cnt), 32'd1);
    chk("err_flit_valid", 32'(flit_valid), 32'd0);
    chk("err_ack_valid", 32'(ack_valid), 32'd0);

    // Reset mid-packet with committed data, a pending ACK and a credit in flight.
    cycle(0, 1, mk(1'b1, 4'd7, 1'b1, 8'h70), 0, 0, 0, 0, 0);
    cycle(0, 1, mk(1'b1, 4'd7, 1'b1, 8'h71), 1, 1, 0, 0, 0);
    cycle(0, 1, mk(1'b1, 4'd8, 1'b1, 8'h72), 0, 0, 0, 1, 0);
    chk("rstm_pre_cred", 32'(grtcred_tx), 32'd2);
    cycle(1, 1, mk(1'b1, 4'd8, 1'b1, 8'h73), 0, 0, 0, 1, 1);
    chk("rstm_flit_valid", 32'(flit_valid), 32'd0);
    chk("rstm_ack_valid", 32'(ack_valid), 32'd0);
    chk("rstm_grtcred", 32'(grtcred_tx), 32'd0);
    chk("rstm_drop_cnt", 32'(drop_cnt), 32'd0);
    cycle(0, 0, '0, 1, 1, 0, 0, 0);
    chk("rstm_empty_commit_ack", 32'(ack_valid), 32'd0);
    chk("rstm_empty_commit_fv", 32'(flit_valid), 32'd0);

    // Randomized traffic against the model.
    cycle(1, 0, '0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 3000; n++) begin
      cycle(0, $urandom_range(0, 99) < 55, 14'($urandom), $urandom_range(0, 99) < 12,
            $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 10,
            $urandom_range(0, 99) < 45, $urandom_range(0, 99) < 40);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
